// File: rtl/barrett_pipelined.sv
// Fully pipelined Barrett reducer: result = x mod m with per-operand m, k, mu.
// Seven register ranks (input capture plus six datapath stages); one operand per clock.
module barrett_pipelined #(
  parameter int WIDTH    = 64,
  parameter int BL_WIDTH = 64
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                start_i,
  input  logic [WIDTH-1:0]    x_i,
  input  logic [WIDTH-1:0]    m_i,
  input  logic [BL_WIDTH-1:0] m_bl_i,
  input  logic [WIDTH-1:0]    mu_i,
  output logic [WIDTH-1:0]    result_o,
  output logic                valid_o
);

  function automatic logic [WIDTH-1:0] cond_sub(input logic [WIDTH-1:0] r,
                                                input logic [WIDTH-1:0] m);
    cond_sub = (r >= m) ? (r - m) : r;
  endfunction

  logic             w_unused_bl;
  assign w_unused_bl = ^m_bl_i[BL_WIDTH-1:7];

  logic             r_vld_p0, r_vld_p1, r_vld_p2, r_vld_p3, r_vld_p4, r_vld_p5;
  logic [WIDTH-1:0] r_x_p0, r_x_p1, r_x_p2, r_x_p3;
  logic [WIDTH-1:0] r_m_p0, r_m_p1, r_m_p2, r_m_p3, r_m_p4, r_m_p5;
  logic [6:0]       r_k_p0, r_k_p1;
  logic [WIDTH-1:0] r_mu_p0, r_mu_p1;
  logic [WIDTH-1:0] r_q1_p1, r_q3_p2, r_p_p3, r_r_p4, r_r_p5;

  logic [6:0]         w_km1;
  logic [7:0]         w_kp1;
  logic [2*WIDTH-1:0] w_q2;
  logic [2*WIDTH-1:0] w_q3_full;
  logic [WIDTH-1:0]   w_p;

  // k-1 wraps for k=0; the oversized shift just yields zero for that slot
  assign w_km1     = r_k_p0 - 7'd1;
  assign w_kp1     = {1'b0, r_k_p1} + 8'd1;
  assign w_q2      = {{WIDTH{1'b0}}, r_q1_p1} * {{WIDTH{1'b0}}, r_mu_p1};
  assign w_q3_full = w_q2 >> w_kp1;
  assign w_p       = r_q3_p2 * r_m_p2;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_vld_p0 <= 1'b0; r_vld_p1 <= 1'b0; r_vld_p2 <= 1'b0;
      r_vld_p3 <= 1'b0; r_vld_p4 <= 1'b0; r_vld_p5 <= 1'b0;
      valid_o  <= 1'b0;
      r_x_p0 <= '0; r_x_p1 <= '0; r_x_p2 <= '0; r_x_p3 <= '0;
      r_m_p0 <= '0; r_m_p1 <= '0; r_m_p2 <= '0;
      r_m_p3 <= '0; r_m_p4 <= '0; r_m_p5 <= '0;
      r_k_p0 <= '0; r_k_p1 <= '0;
      r_mu_p0 <= '0; r_mu_p1 <= '0;
      r_q1_p1 <= '0; r_q3_p2 <= '0; r_p_p3 <= '0;
      r_r_p4  <= '0; r_r_p5  <= '0;
      result_o <= '0;
    end else begin
      // p0: capture operand and its modulus context
      r_vld_p0 <= start_i;
      r_x_p0   <= x_i;
      r_m_p0   <= m_i;
      r_k_p0   <= m_bl_i[6:0];
      r_mu_p0  <= mu_i;
      // p1: q1 = x >> (k-1)
      r_vld_p1 <= r_vld_p0;
      r_q1_p1  <= r_x_p0 >> w_km1;
      r_x_p1   <= r_x_p0;
      r_m_p1   <= r_m_p0;
      r_k_p1   <= r_k_p0;
      r_mu_p1  <= r_mu_p0;
      // p2: q3 = (q1 * mu) >> (k+1); only the low WIDTH bits feed the next product
      r_vld_p2 <= r_vld_p1;
      r_q3_p2  <= w_q3_full[WIDTH-1:0];
      r_x_p2   <= r_x_p1;
      r_m_p2   <= r_m_p1;
      // p3: p = q3 * m mod 2^WIDTH
      r_vld_p3 <= r_vld_p2;
      r_p_p3   <= w_p;
      r_x_p3   <= r_x_p2;
      r_m_p3   <= r_m_p2;
      // p4: r = x - p mod 2^WIDTH
      r_vld_p4 <= r_vld_p3;
      r_r_p4   <= r_x_p3 - r_p_p3;
      r_m_p4   <= r_m_p3;
      // p5: first correction
      r_vld_p5 <= r_vld_p4;
      r_r_p5   <= cond_sub(r_r_p4, r_m_p4);
      r_m_p5   <= r_m_p4;
      // p6: second correction; result holds when no operand arrives
      valid_o  <= r_vld_p5;
      if (r_vld_p5)
        result_o <= cond_sub(r_r_p5, r_m_p5);
    end
  end

endmodule

// File: tb/tb_barrett_pipelined.sv
// Directed and random bench for barrett_pipelined: latency, ordering, reset and values.
module tb_barrett_pipelined;

  localparam logic [63:0] KM  = 64'hD01;
  localparam logic [6:0]  KK  = 7'd12;
  localparam logic [63:0] KMU = 64'h13AF;
  localparam logic [63:0] DM  = 64'h7FE001;
  localparam logic [6:0]  DK  = 7'd23;
  localparam logic [63:0] DMU = 64'h802007;

  logic        clk = 1'b0;
  logic        rst_i = 1'b0;
  logic        start_i = 1'b0;
  logic [63:0] x_i = '0;
  logic [63:0] m_i = '0;
  logic [63:0] m_bl_i = '0;
  logic [63:0] mu_i = '0;
  logic [63:0] result_o;
  logic        valid_o;

  int n_chk = 0;
  int n_err = 0;

  logic        hv [7];
  logic [63:0] hr [7];
  logic [63:0] hold;

  barrett_pipelined #(.WIDTH(64), .BL_WIDTH(64)) dut (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .x_i(x_i), .m_i(m_i),
    .m_bl_i(m_bl_i), .mu_i(mu_i), .result_o(result_o), .valid_o(valid_o)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Apply one cycle of inputs, advance the reference pipe, check outputs after the edge.
  task automatic step(input logic st, input logic rs, input logic [63:0] x,
                      input logic [63:0] m, input logic [6:0] k,
                      input logic [63:0] mu, input logic [63:0] exp);
    start_i = st; rst_i = rs; x_i = x; m_i = m; m_bl_i = {57'd0, k}; mu_i = mu;
    @(posedge clk);
    for (int i = 6; i > 0; i--) begin
      hv[i] = hv[i-1];
      hr[i] = hr[i-1];
    end
    hv[0] = st && !rs;
    hr[0] = exp;
    if (rs) begin
      for (int i = 0; i < 7; i++) begin
        hv[i] = 1'b0;
        hr[i] = '0;
      end
      hold = '0;
    end
    #1;
    if (hv[6]) hold = hr[6];
    check_eq("valid", {63'd0, valid_o}, {63'd0, hv[6]});
    check_eq("result", result_o, hold);
  endtask

  task automatic kyb(input logic [63:0] x, input logic [63:0] exp);
    step(1'b1, 1'b0, x, KM, KK, KMU, exp);
  endtask

  task automatic dil(input logic [63:0] x, input logic [63:0] exp);
    step(1'b1, 1'b0, x, DM, DK, DMU, exp);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, '0, '0, '0, '0);
  endtask

  initial begin
    logic [63:0] xr;
    logic        sel;
    logic        st;
    for (int i = 0; i < 7; i++) begin
      hv[i] = 1'b0;
      hr[i] = '0;
    end
    hold = '0;

    step(1'b0, 1'b1, '0, '0, '0, '0, '0);
    step(1'b0, 1'b1, '0, '0, '0, '0, '0);
    idle(2);

    // single Kyber operand
    kyb(64'h2710, 64'hD);
    idle(8);

    // back-to-back Kyber stream
    kyb(64'h0,      64'h0);
    kyb(64'hD01,    64'h0);
    kyb(64'hD00,    64'hD00);
    kyb(64'hFFFFFF, 64'h950);
    kyb(64'h2710,   64'hD);
    idle(8);

    // Dilithium boundaries: 2m+5 and m-1
    dil(64'hFFC007, 64'h5);
    dil(64'h7FE000, 64'h7FE000);
    idle(8);

    // modulus switching every cycle; 0xFFFFFF mod 8380417 = 16381
    for (int i = 0; i < 4; i++) begin
      kyb(64'hFFFFFF, 64'h950);
      dil(64'hFFFFFF, 64'h3FFD);
    end
    idle(8);

    // reset on the 3rd cycle of a 10-operand burst
    for (int i = 0; i < 10; i++) begin
      xr = 64'd1000 * (i + 1);
      step(1'b1, (i == 2), xr, KM, KK, KMU, xr % KM);
    end
    idle(8);

    // random regression with start gaps
    for (int i = 0; i < 1000; i++) begin
      sel = $urandom_range(0, 1) == 1;
      st  = $urandom_range(0, 3) != 0;
      if (sel) begin
        xr = {$urandom, $urandom} & 64'h0000_3FFF_FFFF_FFFF;
        step(st, 1'b0, xr, DM, DK, DMU, xr % DM);
      end else begin
        xr = {32'd0, $urandom} & 64'hFF_FFFF;
        step(st, 1'b0, xr, KM, KK, KMU, xr % KM);
      end
    end
    idle(8);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
